// File: rtl/apu_cluster_package.sv
// Shared APU cluster constants: FP format, DW flag widths, divsqrt op encoding and latency.
package apu_cluster_package;
  localparam int FP_WIDTH     = 32;
  localparam int SIG_WIDTH    = 23;
  localparam int EXP_WIDTH    = 8;
  localparam int IEEE_COMP    = 1;
  localparam int NDSFLAGS_DIV = 3;
  localparam int NUSFLAGS_DIV = 8;

  typedef enum logic {
    DIVSQRT_OP_DIV  = 1'b0,
    DIVSQRT_OP_SQRT = 1'b1
  } divsqrt_op_e;

  // Default pre+post register count; the arbiter schedules writeback with this.
  localparam int C_DIVSQRT_LATENCY = 3;

  // DW status bit positions.
  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_INVALID = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;
  localparam int ST_DIVZERO = 7;

  localparam logic [FP_WIDTH-1:0] FP_QNAN = 32'h7FC00000;

  typedef struct packed {
    logic [FP_WIDTH-1:0]     res;
    logic [NUSFLAGS_DIV-1:0] status;
  } fp_result_t;
endpackage

// File: rtl/apu_pipe_stage.sv
// Stallable register slice: valid bit plus payload that loads only when a valid op advances.
// Optional APU_DIVSQRT_FLUSH_EN adds flush_i, which clears the valid bit and freezes the payload.
module apu_pipe_stage
  import apu_cluster_package::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef APU_DIVSQRT_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic             vld_i,
  input  logic             adv_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);
  logic load;

`ifdef APU_DIVSQRT_FLUSH_EN
  assign load = adv_i && vld_i && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      vld_o <= 1'b0;
    else if (flush_i) vld_o <= 1'b0;
    else if (adv_i)   vld_o <= vld_i;
  end
`else
  assign load = adv_i && vld_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    vld_o <= 1'b0;
    else if (adv_i) vld_o <= vld_i;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   data_o <= '0;
    else if (load) data_o <= data_i;
  end
endmodule

// File: rtl/fp_divsqrt_pipe_wrapper.sv
// Valid/ready FP divide / square-root unit with configurable pre- and post-core register slices.
// Optional APU_DIVSQRT_FLUSH_EN adds Flush_i to drop every in-flight operation.
module fp_divsqrt_pipe_wrapper
  import apu_cluster_package::*;
#(
  parameter int C_PRE_PIPE_REGS  = 2,
  parameter int C_POST_PIPE_REGS = 1,
  parameter int TAG_WIDTH        = 4,
  parameter int RND_WIDTH        = NDSFLAGS_DIV,
  parameter int STAT_WIDTH       = NUSFLAGS_DIV
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef APU_DIVSQRT_FLUSH_EN
  input  logic                  Flush_i,
`endif
  input  logic                  En_i,
  input  logic                  Op_i,
  input  logic [FP_WIDTH-1:0]   OpA_i,
  input  logic [FP_WIDTH-1:0]   OpB_i,
  input  logic [TAG_WIDTH-1:0]  Tag_i,
  input  logic [RND_WIDTH-1:0]  Rnd_i,
  output logic                  Ready_o,
  output logic [FP_WIDTH-1:0]   Res_o,
  output logic [STAT_WIDTH-1:0] Status_o,
  output logic [TAG_WIDTH-1:0]  Tag_o,
  output logic                  Valid_o,
  input  logic                  Ack_i
);
  localparam int N      = C_PRE_PIPE_REGS + C_POST_PIPE_REGS;
  localparam int PRE_W  = 2 * FP_WIDTH + 1 + TAG_WIDTH + RND_WIDTH;
  localparam int POST_W = FP_WIDTH + STAT_WIDTH + TAG_WIDTH;

  if (N < 1) begin : g_bad_cfg
    $fatal(1, "fp_divsqrt_pipe_wrapper: C_PRE_PIPE_REGS + C_POST_PIPE_REGS must be >= 1");
  end

  // Rounds a normalised 24-bit significand and handles exponent overflow/underflow.
  function automatic fp_result_t pack_round(input logic sign, input logic signed [10:0] exp_in,
                                            input logic [23:0] mant, input logic g,
                                            input logic s, input logic [2:0] rm);
    fp_result_t       r;
    logic             up;
    logic [24:0]      sum;
    logic signed [10:0] e;
    logic [22:0]      frac;
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = !sign && (g || s);
      3'd3:    up = sign && (g || s);
      3'd4:    up = g;
      3'd5:    up = g || s;
      default: up = g && (s || mant[0]);
    endcase
    sum  = {1'b0, mant} + 25'(up);
    e    = exp_in;
    frac = sum[22:0];
    if (sum[24]) begin
      e    = e + 11'sd1;
      frac = sum[23:1];
    end
    r.status             = '0;
    r.status[ST_INEXACT] = g || s;
    if (e > 11'sd254) begin
      r.res                = {sign, 8'hFF, 23'd0};
      r.status[ST_HUGE]    = 1'b1;
      r.status[ST_INF]     = 1'b1;
      r.status[ST_INEXACT] = 1'b1;
    end else if (e < 11'sd1) begin
      r.res                = {sign, 31'd0};
      r.status[ST_TINY]    = 1'b1;
      r.status[ST_ZERO]    = 1'b1;
      r.status[ST_INEXACT] = 1'b1;
    end else begin
      r.res = {sign, e[7:0], frac};
    end
    return r;
  endfunction

  // Restoring integer square root: {root[24:0], remainder != 0}.
  function automatic logic [25:0] isqrt(input logic [49:0] rad);
    logic [26:0] rem;
    logic [26:0] trial;
    logic [24:0] root;
    rem  = '0;
    root = '0;
    for (int i = 24; i >= 0; i--) begin
      rem   = {rem[24:0], rad[2*i+1], rad[2*i]};
      trial = {root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[23:0], 1'b1};
      end else begin
        root = {root[23:0], 1'b0};
      end
    end
    return {root, rem != '0};
  endfunction

  // Denormal operands are treated as zero.
  function automatic fp_result_t fdiv(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] rm);
    fp_result_t         r;
    logic               sign, a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [49:0]        num;
    logic [23:0]        den;
    logic [26:0]        q;
    logic [23:0]        rem;
    logic signed [10:0] e;
    sign   = a[31] ^ b[31];
    a_zero = a[30:23] == 8'h00;
    a_inf  = a[30:23] == 8'hFF && a[22:0] == '0;
    a_nan  = a[30:23] == 8'hFF && a[22:0] != '0;
    b_zero = b[30:23] == 8'h00;
    b_inf  = b[30:23] == 8'hFF && b[22:0] == '0;
    b_nan  = b[30:23] == 8'hFF && b[22:0] != '0;
    num    = {1'b1, a[22:0], 26'd0};
    den    = {1'b1, b[22:0]};
    q      = 27'(num / 50'(den));
    rem    = 24'(num % 50'(den));
    e      = $signed({3'b000, a[30:23]}) - $signed({3'b000, b[30:23]}) + 11'sd127;
    r.res    = '0;
    r.status = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      r.res                = FP_QNAN;
      r.status[ST_INVALID] = 1'b1;
    end else if (a_inf || b_zero) begin
      r.res                = {sign, 8'hFF, 23'd0};
      r.status[ST_INF]     = 1'b1;
      r.status[ST_DIVZERO] = b_zero && !a_inf;
    end else if (a_zero || b_inf) begin
      r.res             = {sign, 31'd0};
      r.status[ST_ZERO] = 1'b1;
    end else if (q[26]) begin
      r = pack_round(sign, e, q[26:3], q[2], (|q[1:0]) || (rem != '0), rm);
    end else begin
      r = pack_round(sign, e - 11'sd1, q[25:2], q[1], q[0] || (rem != '0), rm);
    end
    return r;
  endfunction

  function automatic fp_result_t fsqrt(input logic [31:0] a, input logic [2:0] rm);
    fp_result_t         r;
    logic               a_zero;
    logic signed [10:0] e;
    logic [24:0]        madj;
    logic [25:0]        root;
    a_zero = a[30:23] == 8'h00;
    e      = $signed({3'b000, a[30:23]}) - 11'sd127;
    madj   = {1'b0, 1'b1, a[22:0]};
    if (e[0]) begin
      madj = {1'b1, a[22:0], 1'b0};
      e    = e - 11'sd1;
    end
    root     = isqrt({madj, 25'd0});
    r.res    = '0;
    r.status = '0;
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (a[31] && !a_zero)) begin
      r.res                = FP_QNAN;
      r.status[ST_INVALID] = 1'b1;
    end else if (a_zero) begin
      r.res             = {a[31], 31'd0};
      r.status[ST_ZERO] = 1'b1;
    end else if (a[30:23] == 8'hFF) begin
      r.res            = {1'b0, 8'hFF, 23'd0};
      r.status[ST_INF] = 1'b1;
    end else begin
      r = pack_round(1'b0, (e >>> 1) + 11'sd127, root[25:2], root[1], root[0], rm);
    end
    return r;
  endfunction

  logic [N:0]           vld;
  logic [N+1:1]         adv;
  logic [PRE_W-1:0]     pre_d  [0:C_PRE_PIPE_REGS];
  logic [POST_W-1:0]    post_d [0:C_POST_PIPE_REGS];
  logic [FP_WIDTH-1:0]  core_a, core_b;
  logic                 core_op;
  logic [TAG_WIDTH-1:0] core_tag;
  logic [RND_WIDTH-1:0] core_rnd;
  fp_result_t           div_res, sqrt_res, core_res;

`ifdef APU_DIVSQRT_FLUSH_EN
  assign vld[0]  = En_i && !Flush_i;
  assign Ready_o = adv[1] && !Flush_i;
`else
  assign vld[0]  = En_i;
  assign Ready_o = adv[1];
`endif

  assign adv[N+1] = Ack_i;
  assign pre_d[0] = En_i ? {OpA_i, OpB_i, Op_i, Tag_i, Rnd_i} : '0;

  for (genvar k = 1; k <= N; k++) begin : g_stage
    assign adv[k] = !vld[k] || adv[k+1];
    if (k <= C_PRE_PIPE_REGS) begin : g_pre
      apu_pipe_stage #(.WIDTH(PRE_W)) u_stage (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
`ifdef APU_DIVSQRT_FLUSH_EN
        .flush_i(Flush_i),
`endif
        .vld_i  (vld[k-1]),
        .adv_i  (adv[k]),
        .data_i (pre_d[k-1]),
        .vld_o  (vld[k]),
        .data_o (pre_d[k])
      );
    end else begin : g_post
      apu_pipe_stage #(.WIDTH(POST_W)) u_stage (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
`ifdef APU_DIVSQRT_FLUSH_EN
        .flush_i(Flush_i),
`endif
        .vld_i  (vld[k-1]),
        .adv_i  (adv[k]),
        .data_i (post_d[k-C_PRE_PIPE_REGS-1]),
        .vld_o  (vld[k]),
        .data_o (post_d[k-C_PRE_PIPE_REGS])
      );
    end
  end

  // Core boundary: combinational divide/sqrt between the pre and post slices.
  assign {core_a, core_b, core_op, core_tag, core_rnd} = pre_d[C_PRE_PIPE_REGS];
  assign div_res   = fdiv(core_a, core_b, 3'(core_rnd));
  assign sqrt_res  = fsqrt(core_a, 3'(core_rnd));
  assign core_res  = (core_op == DIVSQRT_OP_SQRT) ? sqrt_res : div_res;
  assign post_d[0] = {core_res.res, STAT_WIDTH'(core_res.status), core_tag};

  assign {Res_o, Status_o, Tag_o} = post_d[C_POST_PIPE_REGS];
  assign Valid_o = vld[N];
endmodule
